fetch_queue: RTL

Instruction fetch stage that sits directly upstream of `decode`. It owns the program counter, issues reads to a synchronous-read instruction memory, and buffers returned words in a 2-entry queue. It presents `PC`/`instruction` to decode under a valid/ready handshake and applies `next_PC_select`/`target_PC` redirects by flushing queued and in-flight fetches.

---
 rtl/fetch_queue.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues synchronous imem reads and buffers
// returned words in a 2-entry queue presented to decode under valid/ready.
//
// Ports:
//   clock, reset             single clock, synchronous active-high reset
//   imem_rd, imem_addr       read request / word-aligned byte address
//   imem_data                read data, valid the cycle after imem_rd
//   next_PC_select,target_PC redirect request from decode (taken on accept)
//   decode_ready             decode accepts the head entry this cycle
//   inst_valid, PC,          head of queue; PC=0 and instruction=NOP
//   instruction              when the queue is empty

module fetch_queue #(
    parameter int ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    imem_rd,
    output logic [ADDRESS_BITS-1:0] imem_addr,
    input  logic [31:0]             imem_data,
    input  logic                    next_PC_select,
    input  logic [ADDRESS_BITS-1:0] target_PC,
    input  logic                    decode_ready,
    output logic                    inst_valid,
    output logic [ADDRESS_BITS-1:0] PC,
    output logic [31:0]             instruction
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [ADDRESS_BITS-1:0] fpc;
    logic [ADDRESS_BITS-1:0] resp_pc;
    logic                    inflight;
    logic [1:0]              count;

    logic [ADDRESS_BITS-1:0] pc0, pc1;
    logic [31:0]             word0, word1;

    logic       head_valid;
    logic       accept;
    logic       redirect;
    logic       issue;
    logic       push;
    logic       push_slot0;
    logic [2:0] occupancy;
    logic [2:0] room;

    // Head is masked during reset so outputs show reset values that cycle.
    assign head_valid = (count != 2'd0) && !reset;
    assign accept     = head_valid && decode_ready;
    assign redirect   = accept && next_PC_select;

    // Words queued plus word in flight, minus the one leaving, must stay < 2.
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign room      = 3'd2 + {2'b00, accept};
    assign issue     = !reset && !redirect && (occupancy < room);

    assign push = inflight && !redirect;

    // Slot the incoming word lands in, after any pop has shifted the queue.
    assign push_slot0 = (count == 2'd0) || ((count == 2'd1) && accept);

    assign imem_rd     = issue;
    assign imem_addr   = reset ? RESET_PC : {fpc[ADDRESS_BITS-1:2], 2'b00};
    assign inst_valid  = head_valid;
    assign PC          = head_valid ? pc0 : '0;
    assign instruction = head_valid ? word0 : NOP;

    always_ff @(posedge clock) begin
        if (reset) begin
            fpc      <= RESET_PC;
            count    <= 2'd0;
            inflight <= 1'b0;
        end else if (redirect) begin
            fpc      <= {target_PC[ADDRESS_BITS-1:2], 2'b00};
            count    <= 2'd0;
            inflight <= 1'b0;
        end else begin
            if (accept) begin
                pc0   <= pc1;
                word0 <= word1;
            end
            if (push) begin
                if (push_slot0) begin
                    pc0   <= resp_pc;
                    word0 <= imem_data;
                end else begin
                    pc1   <= resp_pc;
                    word1 <= imem_data;
                end
            end
            count    <= count + {1'b0, push} - {1'b0, accept};
            inflight <= issue;
            if (issue) begin
                resp_pc <= fpc;
                fpc     <= fpc + ADDRESS_BITS'(4);
            end
        end
    end

endmodule
